// File: rtl/rc_approx_err_monitor_if.sv
// rtl/rc_approx_err_monitor_if.sv - operand/sum bus between the error monitor and the adder under test
interface rc_approx_err_monitor_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] dut_in1;
  logic [WIDTH-1:0] dut_in2;
  logic [WIDTH:0]   dut_sum;

  modport master (output dut_in1, output dut_in2, input dut_sum);
  modport slave  (input dut_in1, input dut_in2, output dut_sum);
endinterface

// File: rtl/rc_approx_err_monitor.sv
// rtl/rc_approx_err_monitor.sv - exhaustive sweep of an approximate adder, accumulating error count, MAE numerator and WCE
module rc_approx_err_monitor #(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  rc_approx_err_monitor_if.master    adder,
  output logic [2*WIDTH:0]           err_count,
  output logic [3*WIDTH:0]           err_sum,
  output logic [WIDTH:0]             wce,
  output logic [WIDTH-1:0]           first_err_a,
  output logic [WIDTH-1:0]           first_err_b,
  output logic                       first_err_vld
);

  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;

  state_t               state_q, state_d;
  logic                 drain_q;
  logic [2*WIDTH-1:0]   cnt_q;
  logic                 start_ok;

  logic                 s1_vld;
  logic [WIDTH:0]       s1_sum;
  logic [WIDTH:0]       s1_exact;
  logic [WIDTH-1:0]     s1_a;
  logic [WIDTH-1:0]     s1_b;
  logic [WIDTH:0]       diff;

  // Operands come straight from the counter register, so the adder path is register-to-register.
  assign adder.dut_in1 = cnt_q[WIDTH-1:0];
  assign adder.dut_in2 = cnt_q[2*WIDTH-1:WIDTH];

  assign start_ok = start && ((state_q == IDLE) || (state_q == DONE));

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE:  if (start) state_d = SWEEP;
      SWEEP: begin
        busy = 1'b1;
        if (&cnt_q) state_d = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (drain_q) state_d = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_d = SWEEP;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      drain_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= (state_q == DRAIN) && !drain_q;
      // Natural wrap at the last pair leaves the operands at 0 outside SWEEP.
      cnt_q   <= (state_q == SWEEP) ? cnt_q + 1'b1 : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld   <= 1'b0;
      s1_sum   <= '0;
      s1_exact <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else begin
      s1_vld   <= (state_q == SWEEP) && !start_ok;
      s1_sum   <= adder.dut_sum;
      s1_exact <= {1'b0, adder.dut_in1} + {1'b0, adder.dut_in2};
      s1_a     <= adder.dut_in1;
      s1_b     <= adder.dut_in2;
    end
  end

  always_comb begin
    diff = '0;
    if (s1_sum >= s1_exact) diff = s1_sum - s1_exact;
    else                    diff = s1_exact - s1_sum;
  end

  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      err_count     <= '0;
      err_sum       <= '0;
      wce           <= '0;
      first_err_a   <= '0;
      first_err_b   <= '0;
      first_err_vld <= 1'b0;
    end else if (s1_vld) begin
      err_count <= err_count + {{(2*WIDTH){1'b0}}, |diff};
      err_sum   <= err_sum + {{(2*WIDTH){1'b0}}, diff};
      if (diff > wce) wce <= diff;
      if (!first_err_vld && (diff != '0)) begin
        first_err_a   <= s1_a;
        first_err_b   <= s1_b;
        first_err_vld <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rc_approx_err_monitor.sv
// tb/tb_rc_approx_err_monitor.sv - scoreboard bench sweeping exact, stuck, offset and approximate adder models
module tb_rc_approx_err_monitor;

  localparam int W = 4;
  localparam int N = 1 << (2 * W);

  logic           clk;
  logic           rst;
  logic           start;
  logic           busy;
  logic           done;
  logic [2*W:0]   err_count;
  logic [3*W:0]   err_sum;
  logic [W:0]     wce;
  logic [W-1:0]   first_err_a;
  logic [W-1:0]   first_err_b;
  logic           first_err_vld;
  int             mode;
  int             tests_run;
  int             tests_failed;

  typedef struct {
    longint cnt;
    longint sum;
    longint wce;
    longint fvld;
    longint fa;
    longint fb;
  } res_t;

  res_t sb[$];

  rc_approx_err_monitor_if #(.WIDTH(W)) bus ();

  rc_approx_err_monitor #(.WIDTH(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .adder         (bus.master),
    .err_count     (err_count),
    .err_sum       (err_sum),
    .wce           (wce),
    .first_err_a   (first_err_a),
    .first_err_b   (first_err_b),
    .first_err_vld (first_err_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 0 exact, 1 stuck at zero, 2 exact+1 mod 2^(W+1), 3 two low stages XOR-only with carry dropped
  function automatic int approx_sum(int m, int a, int b);
    case (m)
      0:       return a + b;
      1:       return 0;
      2:       return (a + b + 1) % (1 << (W + 1));
      default: return (((a >> 2) + (b >> 2)) << 2) | ((a ^ b) & 3);
    endcase
  endfunction

  always_comb bus.dut_sum = (W + 1)'(approx_sum(mode, int'(bus.dut_in1), int'(bus.dut_in2)));

  function automatic res_t model(int m);
    res_t r;
    r = '{0, 0, 0, 0, 0, 0};
    for (int k = 0; k < N; k++) begin
      int a, b, e, s, d;
      a = k % (1 << W);
      b = k >> W;
      e = a + b;
      s = approx_sum(m, a, b);
      d = (s > e) ? s - e : e - s;
      if (d != 0) begin
        r.cnt++;
        if (r.fvld == 0) begin
          r.fvld = 1;
          r.fa   = a;
          r.fb   = b;
        end
      end
      r.sum += d;
      if (d > r.wce) r.wce = d;
    end
    return r;
  endfunction

  task automatic check_eq(input string tag, input longint got, input longint exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_in1"}, bus.dut_in1, 0);
    check_eq({tag, "_in2"}, bus.dut_in2, 0);
    check_eq({tag, "_cnt"}, err_count, 0);
    check_eq({tag, "_sum"}, err_sum, 0);
    check_eq({tag, "_wce"}, wce, 0);
    check_eq({tag, "_fa"}, first_err_a, 0);
    check_eq({tag, "_fb"}, first_err_b, 0);
    check_eq({tag, "_fvld"}, first_err_vld, 0);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_sweep(input int m, input bit poke);
    res_t exp;
    int   cyc;
    mode = m;
    sb.push_back(model(m));
    pulse_start();
    cyc = 1;
    check_eq("t1_busy", busy, 1);
    check_eq("t1_in1", bus.dut_in1, 0);
    check_eq("t1_in2", bus.dut_in2, 0);
    check_eq("t1_cnt_clear", err_count, 0);
    check_eq("t1_fvld_clear", first_err_vld, 0);
    while (!done && cyc < 2 * N + 20) begin
      @(posedge clk); #1;
      cyc++;
      if (poke && cyc == 50) start = 1'b1;
      if (poke && cyc == 51) start = 1'b0;
      if (cyc == N + 2) check_eq("busy_before_done", busy, 1);
    end
    check_eq("done_seen", done, 1);
    check_eq("latency", cyc, N + 3);
    check_eq("busy_at_done", busy, 0);
    exp = sb.pop_front();
    check_eq("err_count", err_count, exp.cnt);
    check_eq("err_sum", err_sum, exp.sum);
    check_eq("wce", wce, exp.wce);
    check_eq("first_err_vld", first_err_vld, exp.fvld);
    check_eq("first_err_a", first_err_a, exp.fa);
    check_eq("first_err_b", first_err_b, exp.fb);
    repeat (3) @(posedge clk);
    #1;
    check_eq("done_held", done, 1);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    mode         = 0;
    rst          = 1'b1;
    start        = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_idle_zero("reset");

    run_sweep(0, 1'b0);
    run_sweep(1, 1'b0);
    check_eq("stuck_cnt_const", err_count, N - 1);
    check_eq("stuck_wce_const", wce, 2 * ((1 << W) - 1));
    run_sweep(2, 1'b0);
    check_eq("plus1_cnt_const", err_count, N);
    check_eq("plus1_sum_const", err_sum, N);
    run_sweep(3, 1'b0);
    check_eq("approx_wce_const", wce, 6);
    check_eq("approx_fa_const", first_err_a, 1);
    check_eq("approx_fb_const", first_err_b, 1);
    run_sweep(3, 1'b1);
    run_sweep(3, 1'b0);

    mode = 3;
    pulse_start();
    repeat (120) @(posedge clk);
    #1;
    check_eq("pre_abort_busy", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_idle_zero("abort");
    run_sweep(3, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
